// File: rtl/serial_rx8.sv
// Serial-to-parallel 8-bit receiver framed by sen; pulses q_valid per good word.
// Optional even-parity bit after each byte when macro PAR_CHECK_EN is defined.
module serial_rx8 #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  input  logic       sen,
  output logic [7:0] q_data,
  output logic       q_valid,
  output logic       busy,
  output logic       err,
  output logic [7:0] word_cnt
);

`ifdef PAR_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;

  // After eight shifts the first bit sits at [7] (MSB_FIRST) or at [0].
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
    if (MSB_FIRST != 0) return {cur[6:0], b};
    else                return {b, cur[7:1]};
  endfunction

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= 8'h00;
      q_data   <= 8'h00;
      q_valid  <= 1'b0;
      err      <= 1'b0;
      word_cnt <= 8'h00;
    end else begin
      q_valid <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (sen) begin
            shreg   <= shift_in(8'h00, sin);
            bit_cnt <= 3'd1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!sen) begin
            err     <= 1'b1;
            bit_cnt <= 3'd0;
            state   <= IDLE;
          end else begin
            shreg   <= shift_in(shreg, sin);
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef PAR_CHECK_EN
              state    <= PARITY;
`else
              q_data   <= shift_in(shreg, sin);
              q_valid  <= 1'b1;
              word_cnt <= word_cnt + 8'd1;
              state    <= IDLE;
`endif
            end
          end
        end
`ifdef PAR_CHECK_EN
        PARITY: begin
          bit_cnt <= 3'd0;
          state   <= IDLE;
          if (!sen) begin
            err <= 1'b1;
          end else if ((^shreg ^ sin) == 1'b0) begin
            q_data   <= shreg;
            q_valid  <= 1'b1;
            word_cnt <= word_cnt + 8'd1;
          end else begin
            err <= 1'b1;
          end
        end
`endif
        default: begin
          bit_cnt <= 3'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx8.sv
// Bench for serial_rx8: MSB-first and LSB-first instances on one stream, checked against a bit-list model.
// Honours PAR_CHECK_EN when defined.
module tb_serial_rx8;

`ifdef PAR_CHECK_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n, sin, sen;
  logic [7:0] qd_m, wc_m, qd_l, wc_l;
  logic       qv_m, bz_m, er_m, qv_l, bz_l, er_l;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: bits of the frame in arrival order.
  int         nbits;
  logic       fb [FRAME];
  logic [7:0] e_qm, e_ql, e_cnt;
  logic       e_v, e_e;

  always #5 clk = ~clk;

  serial_rx8 #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sen(sen),
    .q_data(qd_m), .q_valid(qv_m), .busy(bz_m), .err(er_m), .word_cnt(wc_m));

  serial_rx8 #(.MSB_FIRST(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sen(sen),
    .q_data(qd_l), .q_valid(qv_l), .busy(bz_l), .err(er_l), .word_cnt(wc_l));

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    nbits = 0;
    e_qm = 8'h00; e_ql = 8'h00; e_cnt = 8'h00; e_v = 1'b0; e_e = 1'b0;
  endtask

  task automatic model_edge();
    int vm, vl;
    logic par;
    e_v = 1'b0;
    e_e = 1'b0;
    if (!sen) begin
      if (nbits > 0) e_e = 1'b1;
      nbits = 0;
    end else begin
      fb[nbits] = sin;
      nbits++;
      if (nbits == FRAME) begin
        par = 1'b0;
        for (int i = 0; i < FRAME; i++) par = par ^ fb[i];
        if (FRAME == 9 && par) begin
          e_e = 1'b1;
        end else begin
          vm = 0;
          vl = 0;
          for (int i = 0; i < 8; i++) begin
            vm = vm * 2 + int'(fb[i]);
            vl = vl + int'(fb[i]) * (1 << i);
          end
          e_qm  = 8'(vm);
          e_ql  = 8'(vl);
          e_v   = 1'b1;
          e_cnt = e_cnt + 8'd1;
        end
        nbits = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("q_data_msb",   int'(qd_m), int'(e_qm));
    check("q_data_lsb",   int'(qd_l), int'(e_ql));
    check("q_valid_msb",  int'(qv_m), int'(e_v));
    check("q_valid_lsb",  int'(qv_l), int'(e_v));
    check("err_msb",      int'(er_m), int'(e_e));
    check("err_lsb",      int'(er_l), int'(e_e));
    check("busy_msb",     int'(bz_m), (nbits > 0) ? 1 : 0);
    check("busy_lsb",     int'(bz_l), (nbits > 0) ? 1 : 0);
    check("word_cnt_msb", int'(wc_m), int'(e_cnt));
    check("word_cnt_lsb", int'(wc_l), int'(e_cnt));
  endtask

  task automatic step(input logic s_en, input logic s_in);
    sen = s_en;
    sin = s_in;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Sends s[7] first, then the even-parity bit when parity is built in.
  task automatic send_stream(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) step(1'b1, s[i]);
`ifdef PAR_CHECK_EN
    step(1'b1, ^s);
`endif
  endtask

  // Asserts reset between edges and checks the outputs clear without waiting for a clock.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("rst_err",  int'(er_m), 0);
    check("rst_busy", int'(bz_m), 0);
    check("rst_cnt",  int'(wc_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    sen   = 1'b0;
    sin   = 1'b0;
    model_reset();
    #12;
    compare_all();
    check("reset_q_data", int'(qd_m), 0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    send_stream(8'hA5);
    check("a5_msb", int'(qd_m), 8'hA5);
    check("a5_lsb", int'(qd_l), 8'hA5);
    check("a5_valid", int'(qv_m), 1);
    check("a5_cnt", int'(wc_m), 1);
    step(1'b0, 1'b0);
    check("a5_valid_drop", int'(qv_m), 0);

    send_stream(8'h80);
    check("stream80_msb", int'(qd_m), 8'h80);
    check("stream80_lsb", int'(qd_l), 8'h01);
    step(1'b0, 1'b0);

    for (int i = 7; i >= 3; i--) step(1'b1, i[0]);
    step(1'b0, 1'b1);
    check("abort_err", int'(er_m), 1);
    check("abort_busy", int'(bz_m), 0);
    check("abort_qd", int'(qd_m), 8'h80);
    check("abort_cnt", int'(wc_m), 2);
    step(1'b0, 1'b0);
    check("abort_err_drop", int'(er_m), 0);
    send_stream(8'h3C);
    check("3c_msb", int'(qd_m), 8'h3C);
    check("3c_lsb", int'(qd_l), 8'h3C);
    step(1'b0, 1'b0);

    send_stream(8'h12);
    check("b2b_first", int'(qd_m), 8'h12);
    check("b2b_valid1", int'(qv_m), 1);
    send_stream(8'h34);
    check("b2b_second", int'(qd_m), 8'h34);
    check("b2b_valid2", int'(qv_m), 1);
    step(1'b0, 1'b0);

`ifdef PAR_CHECK_EN
    for (int i = 7; i >= 0; i--) step(1'b1, 1'(8'hA5 >> i));
    step(1'b1, 1'b1);
    check("par_bad_err", int'(er_m), 1);
    check("par_bad_valid", int'(qv_m), 0);
    check("par_bad_qd", int'(qd_m), 8'h34);
    step(1'b0, 1'b0);
`endif

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) != 0), 1'($urandom));
    step(1'b0, 1'b0);

    async_reset();
    for (int i = 0; i < 255; i++) send_stream(8'($urandom));
    check("preload_cnt", int'(wc_m), 255);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    async_reset();
    send_stream(8'h5A);
    check("post_rst_cnt_msb", int'(wc_m), 1);
    check("post_rst_cnt_lsb", int'(wc_l), 1);
    check("post_rst_qd", int'(qd_m), 8'h5A);
    step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
